display_mux: RTL
================

Name: display_mux

Overview:
- Time-multiplexes two 4-bit hex digits onto one shared seven-segment decoder. It drives the decoder's 4-bit nibble input and the two per-digit common-anode enables.
- Sits directly upstream of the hex-to-segment decoder in the dual-digit display path, clocked from the internal HSOSC clock.
- Inserts a blanking interval between digits to prevent ghosting.
- Double-buffers the digit values so a digit never changes mid-display.

Parameters:
- DIGIT_CYCLES, 24000: clock cycles each digit is lit; legal range >= 2.
- BLANK_CYCLES, 240: clock cycles both digits are dark between digits; legal range >= 1.
- CNT_W, 16: width of the dwell counter; must satisfy 2^CNT_W >= max(DIGIT_CYCLES, BLANK_CYCLES).

Ports:
- clk  input  1  system clock (HSOSC output)
- reset  input  1  synchronous, active-high reset
- d0  input  4  digit 0 value (right digit)
- d1  input  4  digit 1 value (left digit)
- load  input  1  single-cycle strobe; captures d0/d1 into pending registers
- s  output  4  nibble to seven-segment decoder
- an  output  2  digit enables, active-low; an[k]=0 lights digit k
- digit_sel  output  1  index of the digit currently selected on s
- frame_tick  output  1  one-cycle pulse on the last cycle of BLANK1

Behaviour:
- One clock domain. Reset is synchronous and active-high and is sampled only on the rising clk edge.
- Registers:
  - pend0, pend1: pending digit values.
  - disp0, disp1: displayed digit values.
  - cnt: CNT_W-bit dwell counter.
  - state: one of four states.
  - All outputs are registered or decoded from state and registers only. There is no combinational path from d0/d1/load to the outputs.
- Reset values: state=BLANK1, cnt=0, pend0=pend1=disp0=disp1=0. Outputs: an=2'b11, s=4'h0, digit_sel=0, frame_tick=0.
- Reset asserted mid-frame returns all registers to their reset values on the next edge. There is no partial-frame completion.
- State sequence: BLANK1 -> SHOW0 -> BLANK0 -> SHOW1 -> BLANK1 ...
  - SHOWk dwells DIGIT_CYCLES cycles.
  - BLANKk dwells BLANK_CYCLES cycles.
  - cnt increments every cycle. When cnt == dwell-1, cnt returns to 0 and state advances.
  - Frame length = 2*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
- Outputs per state:
  - BLANK1: an=11, s=disp0, digit_sel=0 (presets the decoder input before digit 0 lights).
  - SHOW0: an=10, s=disp0, digit_sel=0.
  - BLANK0: an=11, s=disp1, digit_sel=1.
  - SHOW1: an=01, s=disp1, digit_sel=1.
  - an is never 2'b00 in any state.
- frame_tick = 1 exactly when state=BLANK1 and cnt=BLANK_CYCLES-1; otherwise 0.
- load handling:
  - When load=1 at an edge, pend0<=d0 and pend1<=d1.
  - load held high re-captures every cycle.
  - load is ignored while reset=1.
- Display update:
  - On the edge that enters BLANK0 or BLANK1, disp0<=pend0 and disp1<=pend1. At any other time disp is unchanged, so a lit digit never changes value.
  - If load coincides with a blank-entry edge, disp takes the old pend value. The new value reaches disp at the next blank entry.
- Worst-case load-to-visible latency: 1 + (DIGIT_CYCLES + BLANK_CYCLES) + BLANK_CYCLES cycles.

Optional Feature:
- Macro: DISPLAY_MUX_LZB_EN (leading-zero blanking).
- When defined: during SHOW1, if disp1==4'h0 then an=11 (digit 1 dark). State timing, s, digit_sel and frame_tick are unchanged.
- When undefined: digit 1 lights normally, showing 0.

Test Plan (DIGIT_CYCLES=8, BLANK_CYCLES=2; cycle 0 = first edge after reset deasserts):
- Reset check: hold reset 3 cycles -> an=11, s=0, frame_tick=0 throughout. Then cycles 0-1 an=11; cycles 2-9 an=10; cycles 10-11 an=11; cycles 12-19 an=01; frame_tick=1 only at cycle 1, 21, 41.
- Load with latency: load at cycle 5 with d0=A, d1=3 -> s stays 0 in SHOW0 (cycles 2-9); s=3 in SHOW1 (cycles 12-19); s=A in SHOW0 (cycles 22-29).
- Coincident load: load with d0=5 on the edge entering BLANK0 -> SHOW1 shows the old disp1. New d0=5 appears only after the next blank entry (SHOW0 of the following frame).
- Mid-frame reset: assert reset during SHOW1 at cnt=4 -> next cycle an=11, s=0, disp cleared. Restart sequence matches the reset check exactly.
- Invariant: random load/d0/d1 for 2000 cycles -> an never 00; s never changes while an!=11; frame_tick period exactly 20 cycles.
- LZB: with DISPLAY_MUX_LZB_EN, load d1=0, d0=7 -> an=11 during SHOW1, an=10 with s=7 during SHOW0. Without the macro -> an=01 with s=0 during SHOW1.

Source files
------------

// File: rtl/display_mux.sv
// display_mux: time-multiplexes two hex digits onto one shared seven-segment
// decoder with a dark interval between digits and double-buffered digit values.
// Frame: BLANK1 -> SHOW0 -> BLANK0 -> SHOW1, length 2*(DIGIT_CYCLES+BLANK_CYCLES).
// Optional build macro: DISPLAY_MUX_LZB_EN (leading-zero blanking of digit 1).
module display_mux #(
    parameter int DIGIT_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic       load,
    output logic [3:0] s,
    output logic [1:0] an,
    output logic       digit_sel,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        BLANK1 = 2'd0,
        SHOW0  = 2'd1,
        BLANK0 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       pend0;
    logic [3:0]       pend1;
    logic [3:0]       disp0;
    logic [3:0]       disp1;
    logic [CNT_W-1:0] dwell_last;
    logic             dwell_done;
    logic             blank_entry;

    // Dwell end detection and the edge on which a blank state is entered.
    always_comb begin
        dwell_last  = BLANK_LAST;
        if (state == SHOW0 || state == SHOW1) begin
            dwell_last = DIGIT_LAST;
        end
        dwell_done  = (cnt == dwell_last);
        blank_entry = dwell_done && (state == SHOW0 || state == SHOW1);
    end

    // Dwell counter and state sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK1;
            cnt   <= '0;
        end else if (dwell_done) begin
            cnt <= '0;
            case (state)
                BLANK1:  state <= SHOW0;
                SHOW0:   state <= BLANK0;
                BLANK0:  state <= SHOW1;
                default: state <= BLANK1;
            endcase
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pending buffer: captures the digit inputs on every load strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend0 <= 4'h0;
            pend1 <= 4'h0;
        end else if (load) begin
            pend0 <= d0;
            pend1 <= d1;
        end
    end

    // Displayed buffer: only refreshed while entering a blank, so a lit digit
    // never changes; a coincident load lands one blank entry later.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp0 <= 4'h0;
            disp1 <= 4'h0;
        end else if (blank_entry) begin
            disp0 <= pend0;
            disp1 <= pend1;
        end
    end

    // Output decode from state and registers only; BLANK1 presets digit 0 on s.
    always_comb begin
        an         = 2'b11;
        s          = disp0;
        digit_sel  = 1'b0;
        frame_tick = 1'b0;
        case (state)
            BLANK1: begin
                frame_tick = (cnt == BLANK_LAST);
            end
            SHOW0: begin
                an = 2'b10;
            end
            BLANK0: begin
                s         = disp1;
                digit_sel = 1'b1;
            end
            default: begin
                s         = disp1;
                digit_sel = 1'b1;
`ifdef DISPLAY_MUX_LZB_EN
                an        = (disp1 == 4'h0) ? 2'b11 : 2'b01;
`else
                an        = 2'b01;
`endif
            end
        endcase
    end

endmodule
